// File: rtl/fp_align_pkg.sv
// rtl/fp_align_pkg.sv - shared types and constants for the mantissa alignment stage
package fp_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;

  localparam int GRS_W  = 3;
  localparam int DEF_MW = 24;
  localparam int DEF_EW = 8;

endpackage

// File: rtl/fp_align_shift_if.sv
// rtl/fp_align_shift_if.sv - operand/result handshake bundle for the alignment stage
interface fp_align_shift_if
  import fp_align_pkg::*;
#(
  parameter int MW = DEF_MW,
  parameter int EW = DEF_EW
);
  logic                in_valid;
  logic                in_ready;
  logic [EW-1:0]       exp_a;
  logic [EW-1:0]       exp_b;
  logic [EW-1:0]       exp_diff;
  logic                a_lt_b;
  logic [MW-1:0]       man_a;
  logic [MW-1:0]       man_b;
  logic                out_valid;
  logic                out_ready;
  logic [EW-1:0]       exp_out;
  logic [MW-1:0]       man_big;
  logic [MW+GRS_W-1:0] man_small;

  modport master (
    output in_valid, exp_a, exp_b, exp_diff, a_lt_b, man_a, man_b, out_ready,
    input  in_ready, out_valid, exp_out, man_big, man_small
  );

  modport slave (
    input  in_valid, exp_a, exp_b, exp_diff, a_lt_b, man_a, man_b, out_ready,
    output in_ready, out_valid, exp_out, man_big, man_small
  );
endinterface

// File: rtl/fp_align_step.sv
// rtl/fp_align_step.sv - one-bit right shift; sticky merge when FP_ALIGN_STICKY_EN is defined
module fp_align_step
  import fp_align_pkg::*;
#(
  parameter int W = DEF_MW + GRS_W
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

`ifdef FP_ALIGN_STICKY_EN
  // bit 0 accumulates everything that falls past it
  assign dout = {1'b0, din[W-1:2], din[1] | din[0]};
`else
  assign dout = {1'b0, din[W-1:1]};
`endif

endmodule

// File: rtl/fp_align_shift.sv
// rtl/fp_align_shift.sv - iterative mantissa alignment (FP_ALIGN_STICKY_EN enables sticky)
module fp_align_shift
  import fp_align_pkg::*;
#(
  parameter int MW = DEF_MW,
  parameter int EW = DEF_EW
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_align_shift_if.slave   bus
);

  localparam int          W = MW + GRS_W;
  localparam int unsigned L = MW + 2;

  align_state_t  state_q, state_d;
  logic [EW-1:0] count_q;
  logic [W-1:0]  small_q;
  logic [W-1:0]  small_step;
  logic [MW-1:0] big_q;
  logic [EW-1:0] exp_q;

  logic [MW-1:0] small_man;
  logic [W-1:0]  sat_val;
  logic          sat;
  logic          accept;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign small_man = bus.a_lt_b ? bus.man_a : bus.man_b;
  assign sat       = 32'(bus.exp_diff) > L;

`ifdef FP_ALIGN_STICKY_EN
  assign sat_val = {{(W-1){1'b0}}, |small_man};
`else
  assign sat_val = '0;
`endif

  fp_align_step #(.W(W)) u_step (
    .din  (small_q),
    .dout (small_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (sat || bus.exp_diff == '0) state_d = DONE;
          else                           state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q == EW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      small_q <= '0;
      big_q   <= '0;
      exp_q   <= '0;
    end else if (accept) begin
      exp_q   <= bus.a_lt_b ? bus.exp_b : bus.exp_a;
      big_q   <= bus.a_lt_b ? bus.man_b : bus.man_a;
      count_q <= bus.exp_diff;
      small_q <= sat ? sat_val : {small_man, {GRS_W{1'b0}}};
    end else if (state_q == SHIFT) begin
      small_q <= small_step;
      count_q <= count_q - EW'(1);
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.exp_out   = exp_q;
  assign bus.man_big   = big_q;
  assign bus.man_small = small_q;

endmodule
